// File: rtl/microgreen_pkg.sv
// microgreen_pkg: scheduler states, default 25 MHz timing and fault bit indices
package microgreen_pkg;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE       = 3'd0;
    localparam state_t S_TRIG       = 3'd1;
    localparam state_t S_ECHO_WAIT  = 3'd2;
    localparam state_t S_FRAME_WAIT = 3'd3;
    localparam state_t S_INFER      = 3'd4;
    localparam state_t S_INFER_WAIT = 3'd5;
    localparam state_t S_REPORT     = 3'd6;
    localparam int TMR_W_DEF      = 21;
    localparam int PERIOD_CYC_DEF = 1500000;
    localparam int TRIG_CYC_DEF   = 250;
    localparam int ECHO_TMO_DEF   = 1000000;
    localparam int FRAME_TMO_DEF  = 1250000;
    localparam int CONFIRM_N_DEF  = 3;
    localparam int FAULT_ECHO     = 0;
    localparam int FAULT_FRAME    = 1;
endpackage

// File: rtl/microgreen_acq_timer.sv
// microgreen_acq_timer: clearable saturating cycle counter with a >= threshold compare
module microgreen_acq_timer #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] thr,
    output logic         ge
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
    assign ge = cnt_q >= thr;
endmodule

// File: rtl/microgreen_acq_scheduler.sv
// microgreen_acq_scheduler: per-period trigger/echo/frame/inference sequencer with harvest confirmation
module microgreen_acq_scheduler
    import microgreen_pkg::*;
#(
    parameter int TMR_W      = TMR_W_DEF,
    parameter int PERIOD_CYC = PERIOD_CYC_DEF,
    parameter int TRIG_CYC   = TRIG_CYC_DEF,
    parameter int ECHO_TMO   = ECHO_TMO_DEF,
    parameter int FRAME_TMO  = FRAME_TMO_DEF,
    parameter int CONFIRM_N  = CONFIRM_N_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       auto_en,
    input  logic       start,
    input  logic       echo_valid,
    input  logic       frame_done,
    input  logic       infer_done,
    input  logic       prediction,
    output logic       us_trig,
    output logic       cap_arm,
    output logic       infer_start,
    output logic       busy,
    output logic       harvest,
    output logic [1:0] fault
);
    state_t state_q, state_d;
    logic [3:0] confirm_q, confirm_d;
    logic [1:0] fault_q, fault_d;
    logic harvest_q, harvest_d, frame_seen_q, frame_seen_d;
    logic ph_ge, per_ge, trig_entry;
    logic [TMR_W-1:0] ph_thr;
    assign us_trig     = state_q == S_TRIG;
    assign cap_arm     = state_q inside {S_TRIG, S_ECHO_WAIT, S_FRAME_WAIT};
    assign infer_start = state_q == S_INFER;
    assign busy        = state_q != S_IDLE;
    assign harvest     = harvest_q;
    assign fault       = fault_q;
    assign trig_entry  = state_d == S_TRIG && state_q != S_TRIG;
    assign ph_thr = state_q == S_TRIG      ? TMR_W'(TRIG_CYC - 1) :
                    state_q == S_ECHO_WAIT ? TMR_W'(ECHO_TMO - 1) : TMR_W'(FRAME_TMO - 1);
    // phase timer restarts on every state change; cycle timer spans a whole period
    microgreen_acq_timer #(.W(TMR_W)) u_phase (
        .clk(clk), .rst_n(rst_n), .clr(state_d != state_q), .en(ena), .thr(ph_thr), .ge(ph_ge)
    );
    microgreen_acq_timer #(.W(TMR_W)) u_period (
        .clk(clk), .rst_n(rst_n), .clr(trig_entry), .en(ena), .thr(TMR_W'(PERIOD_CYC - 1)), .ge(per_ge)
    );
    always_comb begin
        state_d   = state_q;
        confirm_d = confirm_q;
        fault_d   = fault_q;
        harvest_d = harvest_q;
        if (ena) begin
            case (state_q)
                S_IDLE:       state_d = (start || auto_en) ? S_TRIG : S_IDLE;
                S_TRIG:       state_d = ph_ge ? S_ECHO_WAIT : S_TRIG;
                S_ECHO_WAIT: begin
                    state_d = (echo_valid || ph_ge) ? S_FRAME_WAIT : S_ECHO_WAIT;
                    fault_d[FAULT_ECHO] = fault_q[FAULT_ECHO] | (!echo_valid && ph_ge);
                end
                S_FRAME_WAIT: begin
                    if (frame_seen_q || frame_done) begin
                        state_d = S_INFER;
                    end else if (ph_ge) begin
                        state_d = S_REPORT;
                        fault_d[FAULT_FRAME] = 1'b1;
                        confirm_d = '0;
                    end
                end
                S_INFER:      state_d = S_INFER_WAIT;
                S_INFER_WAIT: begin
                    state_d = infer_done ? S_REPORT : S_INFER_WAIT;
                    confirm_d = !infer_done ? confirm_q : !prediction ? 4'd0 :
                                confirm_q >= 4'(CONFIRM_N) ? 4'(CONFIRM_N) : confirm_q + 4'd1;
                end
                S_REPORT: begin
                    harvest_d = confirm_q == 4'(CONFIRM_N);
                    state_d = !auto_en ? S_IDLE : per_ge ? S_TRIG : S_REPORT;
                end
                default:      state_d = S_IDLE;
            endcase
        end
        if (state_d == S_TRIG && state_q != S_TRIG) fault_d = '0;
    end
    always_comb frame_seen_d = trig_entry ? 1'b0 : (ena && frame_done && cap_arm) ? 1'b1 : frame_seen_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            confirm_q    <= '0;
            fault_q      <= '0;
            harvest_q    <= 1'b0;
            frame_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            confirm_q    <= confirm_d;
            fault_q      <= fault_d;
            harvest_q    <= harvest_d;
            frame_seen_q <= frame_seen_d;
        end
    end
endmodule

// File: tb/tb_microgreen_acq_scheduler.sv
// tb_microgreen_acq_scheduler: table-driven measurement cycles with a report scoreboard
module tb_microgreen_acq_scheduler;
    import microgreen_pkg::*;
    logic clk = 0, rst_n = 0, ena = 1, auto_en = 0, start = 0;
    logic echo_valid = 0, frame_done = 0, infer_done = 0, prediction = 0;
    logic us_trig, cap_arm, infer_start, busy, harvest;
    logic [1:0] fault;
    typedef struct {
        bit use_start, auto_on, chk_space;
        int echo_at, frame_at, ena_at, auto_off_at, pred, inf_n, inf_t;
        bit exp_h;
        logic [1:0] exp_f;
    } vec_t;
    vec_t tbl[15];
    logic [2:0] exp_q[$];
    logic [2:0] mon_e;
    logic [1:0] fault_at_rep;
    int checks = 0, fails = 0, cyc = 0, rep_cnt = 0, last_rise = 0;
    bit rep_pend = 0, was_rep = 0;

    microgreen_acq_scheduler #(
        .PERIOD_CYC(200), .TRIG_CYC(5), .ECHO_TMO(40), .FRAME_TMO(60), .CONFIRM_N(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .auto_en(auto_en), .start(start),
        .echo_valid(echo_valid), .frame_done(frame_done), .infer_done(infer_done),
        .prediction(prediction), .us_trig(us_trig), .cap_arm(cap_arm),
        .infer_start(infer_start), .busy(busy), .harvest(harvest), .fault(fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic vec_t mk(bit us, bit ao, bit sp, int ea, int fa, int en_at, int off,
                                int pr, int inf, int it, bit h, logic [1:0] f);
        vec_t v;
        v.use_start = us; v.auto_on = ao; v.chk_space = sp;
        v.echo_at = ea; v.frame_at = fa; v.ena_at = en_at; v.auto_off_at = off;
        v.pred = pr; v.inf_n = inf; v.inf_t = it; v.exp_h = h; v.exp_f = f;
        return v;
    endfunction

    // Scoreboard: fault checked in the first REPORT cycle, harvest one cycle later
    always @(posedge clk) begin
        #1;
        if (rep_pend) begin
            chk("report_queued", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("harvest", int'(harvest), int'(mon_e[2]));
                chk("fault", int'(fault_at_rep), int'(mon_e[1:0]));
            end
        end
        rep_pend = (dut.state_q === S_REPORT) && !was_rep;
        was_rep  = dut.state_q === S_REPORT;
        if (rep_pend) begin
            fault_at_rep = fault;
            rep_cnt++;
        end
    end

    task automatic run_vec(input vec_t v);
        int n, t, trig_n, inf_n, inf_t, ifd, r0;
        bit froze;
        if (v.auto_on) auto_en = 1;
        if (v.use_start) begin
            repeat (2) step();
            start = 1;
            step();
            start = 0;
        end
        n = 0;
        while (!us_trig && n < 400) begin
            step();
            n++;
        end
        chk("cycle_start", int'(us_trig), 1);
        if (!us_trig) return;
        if (v.chk_space) chk("start_spacing", cyc - last_rise, 200);
        last_rise = cyc;
        exp_q.push_back({v.exp_h, v.exp_f});
        r0 = rep_cnt; t = 0; n = 0; trig_n = 0; inf_n = 0; inf_t = -1; ifd = -1; froze = 0;
        while (rep_cnt == r0 && n < 600) begin
            if (t == v.ena_at && !froze) begin
                ena = 0;
                repeat (10) step();
                ena = 1;
                froze = 1;
            end
            trig_n += int'(us_trig);
            if (infer_start) begin
                inf_n++;
                if (inf_t < 0) inf_t = t;
                ifd = t + 1;
            end
            echo_valid = t == v.echo_at;
            frame_done = t == v.frame_at;
            infer_done = t == ifd;
            prediction = infer_done && v.pred != 0;
            if (t == v.auto_off_at) auto_en = 0;
            step();
            t++;
            n++;
        end
        {echo_valid, frame_done, infer_done, prediction} = '0;
        chk("report_reached", int'(rep_cnt != r0), 1);
        chk("trig_width", trig_n, 5);
        chk("infer_starts", inf_n, v.inf_n);
        if (v.inf_t >= 0) chk("infer_time", inf_t, v.inf_t);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //           st ao sp  echo frame ena off pr inf  it  h  f
        tbl[0]  = mk(1, 0, 0,  10,  20,  -1, -1, 1, 1,  21, 0, 2'b00);
        tbl[1]  = mk(1, 0, 0,  10,   7,   2, -1, 1, 1,  12, 0, 2'b00);
        tbl[2]  = mk(0, 1, 0,  10,  20,  -1, -1, 0, 1,  21, 0, 2'b00);
        tbl[3]  = mk(0, 0, 1,  10,  20,  -1, -1, 1, 1,  21, 0, 2'b00);
        tbl[4]  = mk(0, 0, 1,  10,  20,  -1, -1, 1, 1,  21, 0, 2'b00);
        tbl[5]  = mk(0, 0, 1,  10,  20,  -1, -1, 1, 1,  21, 1, 2'b00);
        tbl[6]  = mk(0, 0, 1,  10,  20,  -1, -1, 1, 1,  21, 1, 2'b00);
        tbl[7]  = mk(0, 0, 1,  10,  20,  -1, -1, 0, 1,  21, 0, 2'b00);
        tbl[8]  = mk(0, 0, 1,  10,  20,  -1, -1, 1, 1,  21, 0, 2'b00);
        tbl[9]  = mk(0, 0, 1,  -1,  20,  -1, -1, 1, 1,  46, 0, 2'b01);
        tbl[10] = mk(0, 0, 1,  10,  20,  -1, -1, 1, 1,  21, 1, 2'b00);
        tbl[11] = mk(0, 0, 1,  10,  -1,  -1, -1, 1, 0,  -1, 0, 2'b10);
        tbl[12] = mk(0, 0, 1,  10,  20,  -1, -1, 1, 1,  21, 0, 2'b00);
        tbl[13] = mk(0, 0, 1,  10,  20,  -1, -1, 1, 1,  21, 0, 2'b00);
        tbl[14] = mk(0, 0, 1,  10,  20,  -1,  1, 1, 1,  21, 1, 2'b00);

        rst_n = 0; start = 1;
        step(); step();
        chk("rst_us_trig", int'(us_trig), 0);
        chk("rst_cap_arm", int'(cap_arm), 0);
        chk("rst_infer_start", int'(infer_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_harvest", int'(harvest), 0);
        chk("rst_fault", int'(fault), 0);
        rst_n = 1; start = 0;
        step();
        chk("idle_after_reset", int'(busy), 0);

        for (int i = 0; i < 15; i++) run_vec(tbl[i]);

        repeat (3) step();
        chk("idle_after_auto_off", int'(busy), 0);
        n = 0;
        repeat (250) begin
            step();
            n += int'(us_trig);
        end
        chk("no_restart_after_auto_off", n, 0);
        chk("harvest_held", int'(harvest), 1);

        start = 1; step(); start = 0; step();
        chk("trig_before_reset", int'(us_trig), 1);
        rst_n = 0;
        step();
        chk("midrst_us_trig", int'(us_trig), 0);
        chk("midrst_cap_arm", int'(cap_arm), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_harvest", int'(harvest), 0);
        chk("midrst_fault", int'(fault), 0);
        rst_n = 1;
        run_vec(tbl[0]);

        repeat (5) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
